fetch_ctrl: RTL

- Sequencer for the fetch stage. Owns the architectural fetch PC and drives the instruction-bus request.
- Holds the request stable until `data_ok`, delivers fetched instructions into a registered fetch-to-decode slot, and absorbs decode back-pressure with a one-entry hold buffer.
- Applies redirects (branch/jump/exception) from later stages. Discards the in-flight response belonging to the squashed path.

---
 rtl/fetch_ctrl_pkg.sv | 31 +++
 rtl/fetch_hold_buf.sv | 37 +++
 rtl/fetch_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared types for the fetch stage: instruction-bus request/response,
// fetch FSM states and the fetch/decode slot payload.
package fetch_ctrl_pkg;

    // Instruction-bus request: address held stable while valid until data_ok.
    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    // Instruction-bus response: one 32-bit instruction per data_ok pulse.
    typedef struct packed {
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        FLUSH
    } fetch_ctrl_state_t;

    // Payload of both the fetch/decode slot and the hold buffer.
    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } fetch_slot_t;

    localparam logic [63:0] PC_STEP = 64'd4;

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry hold buffer catching a fetched instruction while decode stalls.
// Clear (squash) wins over load, load wins over drain.
module fetch_hold_buf
    import fetch_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  fetch_slot_t load_data,
    input  logic        drain,
    input  logic        clear,
    output logic        valid,
    output fetch_slot_t data
);

    // Valid bit: the only state that must be known after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

    // Payload capture on load.
    // NOTE: payload is always qualified by valid, so it carries no reset.
    always_ff @(posedge clk) begin
        if (load) begin
            data <= load_data;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the fetch PC, drives the instruction bus,
// feeds a registered fetch/decode slot and handles redirects.
// Optional macro FETCH_CTRL_PERF_EN adds saturating stall/flush counters.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [63:0] PC_RESET = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output ibus_req_t   ireq,
    input  ibus_resp_t  iresp,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    input  logic        stall_in,
    output logic        out_valid,
    output logic [63:0] out_pc,
    output logic [31:0] out_instr
`ifdef FETCH_CTRL_PERF_EN
    ,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flushed
`endif
);

    fetch_ctrl_state_t state_q, state_d;
    logic [63:0]       pc_q, pc_d;
    logic [63:0]       target_q, target_d;
    fetch_slot_t       slot_q, slot_d;
    logic              out_valid_q, out_valid_d;
    logic              buf_load, buf_drain, buf_clear, buf_valid;
    fetch_slot_t       buf_data;
    fetch_slot_t       fetched;

    assign fetched = '{pc: pc_q, instr: iresp.data};

    fetch_hold_buf u_hold_buf (
        .clk       (clk),
        .reset     (reset),
        .load      (buf_load),
        .load_data (fetched),
        .drain     (buf_drain),
        .clear     (buf_clear),
        .valid     (buf_valid),
        .data      (buf_data)
    );

    // State, PC, redirect target and slot registers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed by the combinational block.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= FETCH;
            pc_q        <= PC_RESET;
            target_q    <= '0;
            slot_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            target_q    <= target_d;
            slot_q      <= slot_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state, bus request and slot update; redirect outranks data_ok and stall.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        state_d     = state_q;
        pc_d        = pc_q;
        target_d    = target_q;
        slot_d      = slot_q;
        out_valid_d = out_valid_q & stall_in;  // a consumed slot empties
        buf_load    = 1'b0;
        buf_drain   = 1'b0;
        buf_clear   = 1'b0;
        ireq.valid  = 1'b0;
        ireq.addr   = pc_q;

        case (state_q)
            FETCH: begin
                ireq.valid = 1'b1;
                if (redirect_valid) begin
                    out_valid_d = 1'b0;
                    if (iresp.data_ok) begin
                        pc_d = redirect_pc;          // response belongs to squashed path
                    end else begin
                        target_d = redirect_pc;      // must wait out the in-flight request
                        state_d  = FLUSH;
                    end
                end else if (iresp.data_ok) begin
                    pc_d = pc_q + PC_STEP;
                    if (!out_valid_q || !stall_in) begin
                        slot_d      = fetched;
                        out_valid_d = 1'b1;
                    end else begin
                        buf_load = 1'b1;
                        state_d  = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    buf_clear   = 1'b1;
                    pc_d        = redirect_pc;
                    out_valid_d = 1'b0;
                    state_d     = FETCH;
                end else if (!stall_in && buf_valid) begin
                    slot_d      = buf_data;
                    out_valid_d = 1'b1;
                    buf_drain   = 1'b1;
                    state_d     = FETCH;
                end
            end
            FLUSH: begin
                ireq.valid  = 1'b1;
                out_valid_d = 1'b0;
                if (redirect_valid) begin
                    target_d = redirect_pc;
                end
                if (iresp.data_ok) begin
                    pc_d    = redirect_valid ? redirect_pc : target_q;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    assign out_valid = out_valid_q;
    assign out_pc    = slot_q.pc;
    assign out_instr = slot_q.instr;

`ifdef FETCH_CTRL_PERF_EN
    logic stall_evt, flush_evt;

    assign stall_evt = (state_q == FETCH) && !iresp.data_ok;
    assign flush_evt = iresp.data_ok &&
                       ((state_q == FLUSH) || ((state_q == FETCH) && redirect_valid));

    // Saturating counters for bus wait cycles and discarded responses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_stall_cycles <= '0;
            perf_flushed      <= '0;
        end else begin
            if (stall_evt && (perf_stall_cycles != '1)) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
            if (flush_evt && (perf_flushed != '1)) begin
                perf_flushed <= perf_flushed + 32'd1;
            end
        end
    end
`endif

endmodule
